window_averager: RTL and testbench
==================================

# window_averager

Parametrised streaming averager. It pops samples from a show-ahead FIFO, sums each non-overlapping window of 2^LOG2_N samples, and emits one average per window over a valid/ready handshake. Truncating or round-half-up division is selectable. It carries its own read control and first-sample tracking, so no external controller is needed. It sits between the sample FIFO and the downstream display/consumer logic in the clk_2 domain.

## Interface
- DATA_W, 8, sample and result width (2..16)
- LOG2_N, 2, log2 of window length N = 2^LOG2_N (1..8)
- ROUND, 0, 0 = truncate, 1 = add N/2 before the shift (round half up)

- clk_2  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fifo_empty  in  1  FIFO empty flag
- data_in  in  DATA_W  FIFO head data, valid whenever fifo_empty=0 (show-ahead)
- fifo_rd  out  1  pop strobe; the head is consumed at the same rising edge
- clear  in  1  synchronous abort: discards the partial window and any pending result
- avg_data  out  DATA_W  window average, stable while avg_valid=1
- avg_valid  out  1  result available
- avg_ready  in  1  consumer accepts the result
- sample_cnt  out  LOG2_N  samples accumulated in the current window

## Operation
- Accumulator acc has DATA_W+LOG2_N bits, which is enough for N·(2^DATA_W−1)+N/2, so it never overflows.
- pop = fifo_rd. fifo_rd = reset_n && !clear && !fifo_empty && !(last && avg_valid && !avg_ready), where last = (sample_cnt == N−1).
- On pop with sample_cnt==0: acc <= data_in. This is the first sample; acc is not cleared separately.
- On pop with 0 < sample_cnt < N−1: acc <= acc + data_in.
- On pop with last=1:
  - sum = acc + data_in.
  - avg_data <= (sum + (ROUND ? N/2 : 0)) >> LOG2_N.
  - avg_valid <= 1 and sample_cnt <= 0.
- On pop when not last: sample_cnt increments by 1.
- Output handshake:
  - avg_valid && avg_ready clears avg_valid, unless a final pop in the same cycle sets it again. Set has priority.
  - avg_data is held while avg_valid=1 and not accepted.
- The next window accumulates while a result waits. Only its final pop stalls behind an unaccepted result.
- clear=1 has priority over everything: sample_cnt <= 0, avg_valid <= 0, fifo_rd=0. acc and avg_data keep their values, which are don't-care.
- Result range: avg_data never exceeds 2^DATA_W−1 in either ROUND mode.

## Timing
- Reset (asynchronous, immediate): acc=0, sample_cnt=0, avg_data=0, avg_valid=0. fifo_rd=0 while reset_n=0.
- fifo_rd is combinational from fifo_empty, avg_ready, clear and state. No registered read latency; data_in is sampled at the edge where fifo_rd=1.
- Latency: avg_valid rises at the same edge that pops the Nth sample of a window.
- Throughput: with FIFO never empty and avg_ready=1, one result every N cycles and fifo_rd held continuously high.
- Empty gaps: fifo_empty=1 holds acc and sample_cnt unchanged for any duration.
- Simultaneous accept and final pop: both happen at the same edge. avg_valid stays 1 and avg_data takes the new value with no bubble.
- Reset asserted mid-window: the partial window is lost. The first pop after release is treated as sample 0.

## Test plan
- Defaults, ROUND=0, FIFO supplies 10,20,30,42 back-to-back, avg_ready=1:
  - fifo_rd high for 4 cycles.
  - avg_valid for 1 cycle with avg_data=25.
  - With ROUND=1, avg_data=26.
- Saturation: 4× 255 in both ROUND modes -> avg_data=255, no wrap. DATA_W=8, LOG2_N=8, 256× 255 -> 255.
- Back-pressure, avg_ready=0 after window 1 (avg 25):
  - Window 2 (1,2,3,6) pops 3 samples, then fifo_rd=0 with sample_cnt=3 and the FIFO non-empty; avg_data stays 25.
  - Raise avg_ready: the final pop and the accept happen at the same edge; next cycle avg_valid=1 and avg_data=3.
- Gaps: fifo_empty=1 for 5 cycles between each of 4,4,8,8 -> sample_cnt steps 1,2,3,0 and avg_data=6. acc is unchanged during the gaps.
- clear:
  - After 2 samples, sample_cnt=0; the next 4 samples 100,100,100,100 give avg_data=100.
  - clear while avg_valid=1 drops avg_valid at the next edge with no handshake.
  - clear with FIFO non-empty keeps fifo_rd=0.
- Async reset mid-window (sample_cnt=2) and while avg_valid=1: all outputs 0 immediately and fifo_rd=0. After release, a fresh window of 5,5,5,5 gives avg_data=5.

Source files
------------

// File: rtl/window_averager.sv
// Streaming window averager: pops a show-ahead FIFO, sums 2^LOG2_N samples,
// and emits one truncated or rounded average per window over valid/ready.
module window_averager #(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 2,
    parameter bit ROUND  = 1'b0
) (
    input  logic              clk_2,
    input  logic              reset_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] data_in,
    output logic              fifo_rd,
    input  logic              clear,
    output logic [DATA_W-1:0] avg_data,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic [LOG2_N-1:0] sample_cnt
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [ACC_W-1:0] HALF =
        ROUND ? (ACC_W'(1) << (LOG2_N - 1)) : '0;
    localparam logic [LOG2_N-1:0] LAST = '1;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sample_ext;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  rounded;
    logic [DATA_W-1:0] avg_next;
    logic              last;
    logic              stall;

    // Zero-extended head sample and the running/final window sums
    assign sample_ext = ACC_W'(data_in);
    assign sum        = acc + sample_ext;
    assign rounded    = sum + HALF;
    assign avg_next   = DATA_W'(rounded >> LOG2_N);

    // Only the closing pop of a window waits behind an unaccepted result
    assign last    = (sample_cnt == LAST);
    assign stall   = last && avg_valid && !avg_ready;
    assign fifo_rd = reset_n && !clear && !fifo_empty && !stall;

    // Accumulate, close windows, and run the result handshake
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            sample_cnt <= '0;
            avg_data   <= '0;
            avg_valid  <= 1'b0;
        end else if (clear) begin
            sample_cnt <= '0;
            avg_valid  <= 1'b0;
        end else begin
            if (avg_valid && avg_ready) begin
                avg_valid <= 1'b0;
            end
            if (fifo_rd) begin
                if (last) begin
                    avg_data   <= avg_next;
                    avg_valid  <= 1'b1;
                    sample_cnt <= '0;
                end else begin
                    acc        <= (sample_cnt == '0) ? sample_ext : sum;
                    sample_cnt <= sample_cnt + LOG2_N'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_window_averager.sv
// Bench for window_averager: vector table, hand-written corner sequences,
// and a randomized run against a window-sum reference model.
module tb_window_averager;

    typedef struct {
        logic [3:0][7:0] s;
        int              e0;
        int              e1;
    } vec_t;

    logic       clk_2      = 1'b0;
    logic       reset_n    = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] data_in    = '0;
    logic       clear      = 1'b0;
    logic       avg_ready  = 1'b1;
    logic       fifo_rd;
    logic       avg_valid;
    logic [7:0] avg_data;
    logic [1:0] sample_cnt;

    logic       fifo_rd_r;
    logic       avg_valid_r;
    logic [7:0] avg_data_r;
    logic [1:0] sample_cnt_r;

    logic       fifo_empty_w = 1'b1;
    logic [7:0] data_in_w    = 8'hff;
    logic       clear_w      = 1'b0;
    logic       avg_ready_w  = 1'b1;
    logic       fifo_rd_w;
    logic       avg_valid_w;
    logic [7:0] avg_data_w;
    logic [7:0] sample_cnt_w;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q[$];
    bit         hold = 1'b0;
    vec_t       tbl[8];

    window_averager u_dut (
        .clk_2      (clk_2),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .data_in    (data_in),
        .fifo_rd    (fifo_rd),
        .clear      (clear),
        .avg_data   (avg_data),
        .avg_valid  (avg_valid),
        .avg_ready  (avg_ready),
        .sample_cnt (sample_cnt)
    );

    window_averager #(.DATA_W(8), .LOG2_N(2), .ROUND(1'b1)) u_dut_r (
        .clk_2      (clk_2),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .data_in    (data_in),
        .fifo_rd    (fifo_rd_r),
        .clear      (clear),
        .avg_data   (avg_data_r),
        .avg_valid  (avg_valid_r),
        .avg_ready  (avg_ready),
        .sample_cnt (sample_cnt_r)
    );

    window_averager #(.DATA_W(8), .LOG2_N(8), .ROUND(1'b0)) u_dut_w (
        .clk_2      (clk_2),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty_w),
        .data_in    (data_in_w),
        .fifo_rd    (fifo_rd_w),
        .clear      (clear_w),
        .avg_data   (avg_data_w),
        .avg_valid  (avg_valid_w),
        .avg_ready  (avg_ready_w),
        .sample_cnt (sample_cnt_w)
    );

    always #5 clk_2 = ~clk_2;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive();
        fifo_empty = hold || (q.size() == 0);
        data_in    = (q.size() != 0) ? q[0] : 8'd0;
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    task automatic tick();
        logic r;
        drive();
        #1;
        r = fifo_rd;
        @(posedge clk_2);
        #1;
        if (r && q.size() != 0) void'(q.pop_front());
        drive();
    endtask

    task automatic apply_reset();
        reset_n      = 1'b0;
        q.delete();
        hold         = 1'b0;
        clear        = 1'b0;
        avg_ready    = 1'b1;
        fifo_empty_w = 1'b1;
        drive();
        #2;
        reset_n = 1'b1;
        @(posedge clk_2);
        #1;
    endtask

    task automatic push4(input int v);
        for (int k = 0; k < 4; k++) q.push_back(8'(v));
    endtask

    function automatic vec_t mk(input int a, input int b, input int c,
                                input int d, input int e0, input int e1);
        vec_t v;
        v.s[0] = 8'(a);
        v.s[1] = 8'(b);
        v.s[2] = 8'(c);
        v.s[3] = 8'(d);
        v.e0   = e0;
        v.e1   = e1;
        return v;
    endfunction

    initial begin
        int  win[$];
        bit  pend;
        int  e0;
        int  e1;
        int  s;
        bit  er;
        int  gexp[4];

        tbl[0] = mk(10, 20, 30, 42, 25, 26);
        tbl[1] = mk(255, 255, 255, 255, 255, 255);
        tbl[2] = mk(0, 0, 0, 0, 0, 0);
        tbl[3] = mk(1, 2, 3, 6, 3, 3);
        tbl[4] = mk(1, 1, 1, 2, 1, 1);
        tbl[5] = mk(1, 1, 2, 2, 1, 2);
        tbl[6] = mk(0, 0, 0, 1, 0, 0);
        tbl[7] = mk(100, 100, 100, 100, 100, 100);
        gexp   = '{1, 2, 3, 0};

        // reset values, immediate and with FIFO non-empty
        #1;
        q.push_back(8'd77);
        reset_n = 1'b0;
        drive();
        #1;
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_valid", avg_valid, 0);
        chk("rst_data", avg_data, 0);
        chk("rst_rd", fifo_rd, 0);
        chk("rst_valid_w", avg_valid_w, 0);
        @(posedge clk_2);
        #1;
        chk("rst_rd_held", fifo_rd, 0);
        reset_n = 1'b1;
        q.delete();
        drive();
        @(posedge clk_2);
        #1;
        chk("post_rst_cnt", sample_cnt, 0);

        // 256 x 255 with LOG2_N=8
        fifo_empty_w = 1'b0;
        settle();
        chk("wide_rd", fifo_rd_w, 1);
        repeat (255) tick();
        chk("wide_cnt255", sample_cnt_w, 255);
        chk("wide_valid_early", avg_valid_w, 0);
        tick();
        fifo_empty_w = 1'b1;
        chk("wide_valid", avg_valid_w, 1);
        chk("wide_data", avg_data_w, 255);
        chk("wide_cnt0", sample_cnt_w, 0);

        // vector table, back-to-back windows with avg_ready=1
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) q.push_back(tbl[i].s[k]);
            avg_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                settle();
                chk("vec_rd", fifo_rd, 1);
                chk("vec_valid_lo", avg_valid, 0);
                tick();
            end
            chk("vec_valid", avg_valid, 1);
            chk("vec_avg", avg_data, tbl[i].e0);
            chk("vec_avg_round", avg_data_r, tbl[i].e1);
            chk("vec_cnt", sample_cnt, 0);
            tick();
            chk("vec_valid_1cyc", avg_valid, 0);
        end

        // back-pressure: final pop stalls behind the pending result
        avg_ready = 1'b0;
        push4(0);
        q.delete();
        q.push_back(8'd10); q.push_back(8'd20);
        q.push_back(8'd30); q.push_back(8'd42);
        q.push_back(8'd1);  q.push_back(8'd2);
        q.push_back(8'd3);  q.push_back(8'd6);
        repeat (4) tick();
        chk("bp_valid1", avg_valid, 1);
        chk("bp_avg1", avg_data, 25);
        repeat (3) tick();
        settle();
        chk("bp_stall_rd", fifo_rd, 0);
        chk("bp_cnt3", sample_cnt, 3);
        chk("bp_hold_avg", avg_data, 25);
        repeat (2) tick();
        chk("bp_cnt3_held", sample_cnt, 3);
        chk("bp_avg_held", avg_data, 25);
        avg_ready = 1'b1;
        settle();
        chk("bp_release_rd", fifo_rd, 1);
        tick();
        chk("bp_valid2", avg_valid, 1);
        chk("bp_avg2", avg_data, 3);
        chk("bp_avg2_round", avg_data_r, 3);
        chk("bp_cnt0", sample_cnt, 0);
        tick();
        chk("bp_valid_drop", avg_valid, 0);

        // empty gaps between samples
        q.push_back(8'd4); q.push_back(8'd4);
        q.push_back(8'd8); q.push_back(8'd8);
        for (int k = 0; k < 4; k++) begin
            hold = 1'b0;
            tick();
            chk("gap_cnt", sample_cnt, gexp[k]);
            if (k < 3) begin
                hold = 1'b1;
                for (int g = 0; g < 5; g++) begin
                    settle();
                    chk("gap_rd", fifo_rd, 0);
                    tick();
                    chk("gap_cnt_held", sample_cnt, gexp[k]);
                end
            end
        end
        hold = 1'b0;
        chk("gap_valid", avg_valid, 1);
        chk("gap_avg", avg_data, 6);
        chk("gap_avg_round", avg_data_r, 6);
        tick();

        // clear: partial window discard and pending result drop
        q.push_back(8'd7);
        q.push_back(8'd9);
        tick();
        tick();
        chk("clr_cnt2", sample_cnt, 2);
        push4(100);
        clear = 1'b1;
        settle();
        chk("clr_rd", fifo_rd, 0);
        tick();
        chk("clr_cnt0", sample_cnt, 0);
        clear     = 1'b0;
        avg_ready = 1'b0;
        repeat (4) tick();
        chk("clr_valid", avg_valid, 1);
        chk("clr_avg", avg_data, 100);
        chk("clr_avg_round", avg_data_r, 100);
        tick();
        chk("clr_valid_held", avg_valid, 1);
        clear = 1'b1;
        tick();
        chk("clr_valid_drop", avg_valid, 0);
        clear     = 1'b0;
        avg_ready = 1'b1;

        // async reset mid-window
        q.push_back(8'd3); q.push_back(8'd3); q.push_back(8'd3);
        tick();
        tick();
        chk("ar_cnt2", sample_cnt, 2);
        reset_n = 1'b0;
        #1;
        chk("ar_cnt", sample_cnt, 0);
        chk("ar_valid", avg_valid, 0);
        chk("ar_data", avg_data, 0);
        chk("ar_rd", fifo_rd, 0);
        #2;
        reset_n = 1'b1;
        q.delete();
        drive();
        @(posedge clk_2);
        #1;
        push4(5);
        repeat (4) tick();
        chk("ar_fresh_valid", avg_valid, 1);
        chk("ar_fresh_avg", avg_data, 5);
        tick();

        // async reset while a result is pending
        avg_ready = 1'b0;
        push4(9);
        repeat (4) tick();
        chk("ar2_valid_pre", avg_valid, 1);
        chk("ar2_avg_pre", avg_data, 9);
        reset_n = 1'b0;
        #1;
        chk("ar2_valid", avg_valid, 0);
        chk("ar2_data", avg_data, 0);
        chk("ar2_data_round", avg_data_r, 0);
        #2;
        reset_n = 1'b1;
        drive();
        @(posedge clk_2);
        #1;

        // randomized run against a window-sum model
        apply_reset();
        pend = 1'b0;
        e0   = 0;
        e1   = 0;
        for (int c = 0; c < 1500; c++) begin
            hold      = ($urandom_range(0, 3) == 0);
            avg_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 49) == 0);
            if (q.size() < 3 && $urandom_range(0, 1) == 1)
                q.push_back(8'($urandom_range(0, 255)));
            settle();
            er = !clear && !fifo_empty;
            if (win.size() == 3 && pend && !avg_ready) er = 1'b0;
            chk("rnd_rd", fifo_rd, er);
            chk("rnd_rd_r", fifo_rd_r, er);
            chk("rnd_cnt", sample_cnt, win.size());
            chk("rnd_cnt_r", sample_cnt_r, win.size());
            chk("rnd_valid", avg_valid, pend);
            chk("rnd_valid_r", avg_valid_r, pend);
            if (pend) begin
                chk("rnd_avg", avg_data, e0);
                chk("rnd_avg_round", avg_data_r, e1);
            end
            if (clear) begin
                win.delete();
                pend = 1'b0;
            end else begin
                if (pend && avg_ready) pend = 1'b0;
                if (er) begin
                    win.push_back(int'(q[0]));
                    if (win.size() == 4) begin
                        s    = win.sum();
                        e0   = s / 4;
                        e1   = (s + 2) / 4;
                        pend = 1'b1;
                        win.delete();
                    end
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
